// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared widths, request field layout, FSM states and request unpacking
package ram_responder_pkg;
    localparam int NUM_RAM_ADDRESS = 256;
    localparam int DATA_W          = 32;
    localparam int ADDR_W          = $clog2(NUM_RAM_ADDRESS);
    localparam int REQ_W           = ADDR_W + DATA_W + 1;
    localparam int RW_BIT          = REQ_W - 1;
    localparam int ADDR_MSB        = REQ_W - 2;
    localparam int ADDR_LSB        = DATA_W;
    localparam int WDATA_MSB       = DATA_W - 1;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_RD, RESP} state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic req_t unpack_req(input logic [REQ_W-1:0] req);
        req_t r;
        r.rw    = req[RW_BIT];
        r.addr  = req[ADDR_MSB:ADDR_LSB];
        r.wdata = req[WDATA_MSB:0];
        return r;
    endfunction
endpackage

// File: rtl/ram_request_responder_sat_counter16.sv
// sat_counter16: 16-bit event counter with synchronous clear that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);
    // count events, never wrapping past 16'hFFFF
    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule

// File: rtl/ram_request_responder.sv
// ram_request_responder: pops one packed request, drives one RAM access, returns read data; RESP_STATS_EN adds rd/wr counters
module ram_request_responder
    import ram_responder_pkg::*;
#(
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              req_empty,
    input  logic [REQ_W-1:0]  req_data,
    output logic              req_pop,
    output logic              ram_enable,
    output logic              ram_read_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_write,
    input  logic [DATA_W-1:0] ram_data_read,
    input  logic              resp_full,
    output logic              resp_push,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
`ifdef RESP_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);
    localparam logic [1:0] LAT_INIT = 2'(RAM_READ_LATENCY - 1);

    state_t            state, next_state;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        lat_cnt;

    assign ram_read_write = rw_q;
    assign ram_addr       = addr_q;
    assign ram_data_write = wdata_q;

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : next_state;
    end

    // sequencing: one request in flight, reads wait out the RAM latency then the response FIFO
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (enable && !req_empty) ? FETCH : IDLE;
            FETCH:   next_state = EXEC;
            EXEC:    next_state = rw_q ? IDLE : WAIT_RD;
            WAIT_RD: next_state = (lat_cnt == 2'd0) ? RESP : WAIT_RD;
            RESP:    next_state = resp_full ? RESP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // strobes are held low while reset is asserted so nothing leaks out of an abandoned transaction
    always_comb begin
        req_pop    = !reset && state == IDLE && enable && !req_empty;
        ram_enable = !reset && state == EXEC;
        resp_push  = !reset && state == RESP && !resp_full;
        busy       = !reset && state != IDLE;
    end

    // request capture, read-latency countdown and response word
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt   <= 2'd0;
            resp_data <= '0;
        end else begin
            if (state == FETCH)
                {rw_q, addr_q, wdata_q} <= unpack_req(req_data);
            if (state == EXEC && !rw_q)
                lat_cnt <= LAT_INIT;
            if (state == WAIT_RD) begin
                if (lat_cnt == 2'd0)
                    resp_data <= ram_data_read;
                else
                    lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

`ifdef RESP_STATS_EN
    sat_counter16 u_wr_count (
        .clk  (clk),
        .clear(reset),
        .inc  (ram_enable && rw_q),
        .count(wr_count)
    );

    sat_counter16 u_rd_count (
        .clk  (clk),
        .clear(reset),
        .inc  (resp_push),
        .count(rd_count)
    );
`endif
endmodule

// File: tb/tb_ram_request_responder.sv
// tb_ram_request_responder: randomized bench with FIFO/RAM models and an in-order response scoreboard
module tb_ram_request_responder;
    import ram_responder_pkg::*;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic req_empty0 = 1'b1, req_empty1 = 1'b1, resp_full0 = 1'b0, resp_full1 = 1'b0;
    logic [REQ_W-1:0] req_data0 = '0, req_data1 = '0;
    logic [DATA_W-1:0] ram_data_read0 = '0, ram_data_read1 = '0;
    logic req_pop0, ram_enable0, ram_read_write0, resp_push0, busy0;
    logic req_pop1, ram_enable1, ram_read_write1, resp_push1, busy1;
    logic [ADDR_W-1:0] ram_addr0, ram_addr1;
    logic [DATA_W-1:0] ram_data_write0, ram_data_write1, resp_data0, resp_data1;
`ifdef RESP_STATS_EN
    logic [15:0] rd_count0, wr_count0, rd_count1, wr_count1;
`endif

    always #5 clk = ~clk;

    ram_request_responder #(.RAM_READ_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .req_empty(req_empty0), .req_data(req_data0),
        .req_pop(req_pop0), .ram_enable(ram_enable0), .ram_read_write(ram_read_write0),
        .ram_addr(ram_addr0), .ram_data_write(ram_data_write0), .ram_data_read(ram_data_read0),
        .resp_full(resp_full0), .resp_push(resp_push0), .resp_data(resp_data0), .busy(busy0)
`ifdef RESP_STATS_EN
        , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
    );

    ram_request_responder #(.RAM_READ_LATENCY(3)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .req_empty(req_empty1), .req_data(req_data1),
        .req_pop(req_pop1), .ram_enable(ram_enable1), .ram_read_write(ram_read_write1),
        .ram_addr(ram_addr1), .ram_data_write(ram_data_write1), .ram_data_read(ram_data_read1),
        .resp_full(resp_full1), .resp_push(resp_push1), .resp_data(resp_data1), .busy(busy1)
`ifdef RESP_STATS_EN
        , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
    );

    int vectors = 0, miscompares = 0, cyc = 0, n_wr = 0, n_rd = 0;
    logic [REQ_W-1:0]  req_q0[$], req_q1[$];
    logic [DATA_W-1:0] ram_mem[NUM_RAM_ADDRESS], exp_mem[NUM_RAM_ADDRESS];
    logic [DATA_W-1:0] exp0[$], got0[$], exp1[$], got1[$];
    int pop_cyc[$], en_cyc[$], push_cyc[$], en1_q[$];
    logic en_rw[$];
    logic [ADDR_W-1:0] en_addr[$];
    logic [DATA_W-1:0] en_wd[$];

    // one clock: sample strobes mid-cycle, then after the edge act as request FIFO, RAM and response FIFO
    task automatic tick();
        logic p0, e0, w0, p1;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        @(negedge clk);
        p0 = req_pop0; e0 = ram_enable0; w0 = ram_read_write0; a0 = ram_addr0; d0 = ram_data_write0;
        p1 = req_pop1;
        if (p0) pop_cyc.push_back(cyc);
        if (e0) begin
            en_cyc.push_back(cyc); en_rw.push_back(w0); en_addr.push_back(a0); en_wd.push_back(d0);
        end
        if (resp_push0) begin
            push_cyc.push_back(cyc); got0.push_back(resp_data0);
        end
        if (ram_enable1) en1_q.push_back(cyc);
        if (resp_push1) got1.push_back(resp_data1);
        @(posedge clk);
        #1;
        cyc++;
        if (p0 && req_q0.size() != 0) req_data0 = req_q0.pop_front();
        req_empty0 = req_q0.size() == 0;
        if (e0 && w0) ram_mem[a0] = d0;
        ram_data_read0 = (e0 && !w0) ? ram_mem[a0] : $urandom;
        if (p1 && req_q1.size() != 0) req_data1 = req_q1.pop_front();
        req_empty1 = req_q1.size() == 0;
        ram_data_read1 = $urandom;
        if (en1_q.size() != 0 && en1_q[0] + 3 == cyc) begin
            exp1.push_back(ram_data_read1);
            void'(en1_q.pop_front());
        end
    endtask

    // enqueue a request and update the architectural model: writes update memory, reads expect its word
    task automatic push_req0(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_q0.push_back({rw, a, d});
        req_empty0 = 1'b0;
        if (rw) begin
            exp_mem[a] = d; n_wr++;
        end else begin
            exp0.push_back(exp_mem[a]); n_rd++;
        end
    endtask

    task automatic clear_logs();
        pop_cyc.delete(); en_cyc.delete(); push_cyc.delete();
        en_rw.delete(); en_addr.delete(); en_wd.delete();
        got0.delete(); exp0.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        tick(); tick();
        vectors++;
        if ({req_pop0, ram_enable0, resp_push0, busy0} !== 4'b0) begin
            miscompares++; $display("FAIL reset_strobes got=%b exp=0000", {req_pop0, ram_enable0, resp_push0, busy0});
        end
        vectors++;
        if ({ram_read_write0, ram_addr0, ram_data_write0} !== '0) begin
            miscompares++; $display("FAIL reset_ram_bus got=%h exp=0", {ram_read_write0, ram_addr0, ram_data_write0});
        end
        vectors++;
        if (resp_data0 !== '0) begin
            miscompares++; $display("FAIL reset_resp_data got=%h exp=0", resp_data0);
        end
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy1 got=%b exp=0", busy1);
        end
        reset = 1'b0; n_wr = 0; n_rd = 0;
        tick();
    endtask

    task automatic test_single_write();
        clear_logs();
        enable = 1'b1;
        push_req0(1'b1, 8'h2A, 32'hDEADBEEF);
        repeat (8) tick();
        vectors++;
        if (pop_cyc.size() !== 1 || en_cyc.size() !== 1) begin
            miscompares++; $display("FAIL wr_counts got pops=%0d strobes=%0d exp 1/1", pop_cyc.size(), en_cyc.size());
        end
        if (pop_cyc.size() == 1 && en_cyc.size() == 1) begin
            vectors++;
            if (en_cyc[0] - pop_cyc[0] !== 2) begin
                miscompares++; $display("FAIL wr_strobe_delay got=%0d exp=2", en_cyc[0] - pop_cyc[0]);
            end
            vectors++;
            if ({en_rw[0], en_addr[0], en_wd[0]} !== {1'b1, 8'h2A, 32'hDEADBEEF}) begin
                miscompares++; $display("FAIL wr_ram_bus got=%b/%h/%h exp=1/2a/deadbeef", en_rw[0], en_addr[0], en_wd[0]);
            end
        end
        vectors++;
        if (push_cyc.size() !== 0) begin
            miscompares++; $display("FAIL wr_no_push got=%0d exp=0", push_cyc.size());
        end
    endtask

    task automatic test_read_after_write();
        clear_logs();
        push_req0(1'b0, 8'h2A, $urandom);
        repeat (10) tick();
        vectors++;
        if (en_cyc.size() !== 1 || push_cyc.size() !== 1 || pop_cyc.size() !== 1) begin
            miscompares++; $display("FAIL rd_counts got strobes=%0d pushes=%0d pops=%0d exp 1/1/1", en_cyc.size(), push_cyc.size(), pop_cyc.size());
        end
        if (en_cyc.size() == 1 && push_cyc.size() == 1 && pop_cyc.size() == 1) begin
            vectors++;
            if (en_rw[0] !== 1'b0) begin
                miscompares++; $display("FAIL rd_rw got=%b exp=0", en_rw[0]);
            end
            vectors++;
            if (push_cyc[0] - pop_cyc[0] !== 4) begin
                miscompares++; $display("FAIL rd_push_delay got=%0d exp=4", push_cyc[0] - pop_cyc[0]);
            end
            vectors++;
            if (got0[0] !== 32'hDEADBEEF) begin
                miscompares++; $display("FAIL rd_data got=%h exp=deadbeef", got0[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int c_drop;
        clear_logs();
        a = ADDR_W'($urandom); d = $urandom;
        resp_full0 = 1'b1;
        push_req0(1'b1, a, d);
        push_req0(1'b0, a, $urandom);
        repeat (8) tick();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({busy0, resp_data0, push_cyc.size() == 0} !== {1'b1, d, 1'b1}) begin
                miscompares++; $display("FAIL bp_hold[%0d] got busy=%b data=%h pushes=%0d exp 1/%h/0", i, busy0, resp_data0, push_cyc.size(), d);
            end
            tick();
        end
        resp_full0 = 1'b0;
        c_drop = cyc;
        tick();
        vectors++;
        if (push_cyc.size() !== 1 || got0.size() !== 1) begin
            miscompares++; $display("FAIL bp_release got pushes=%0d exp=1", push_cyc.size());
        end else begin
            vectors++;
            if (push_cyc[0] !== c_drop || got0[0] !== d) begin
                miscompares++; $display("FAIL bp_push got cyc=%0d data=%h exp cyc=%0d data=%h", push_cyc[0], got0[0], c_drop, d);
            end
        end
        vectors++;
        if (busy0 !== 1'b0) begin
            miscompares++; $display("FAIL bp_idle got busy=%b exp=0", busy0);
        end
    endtask

    task automatic test_gating();
        int c_en;
        clear_logs();
        enable = 1'b0;
        push_req0(1'b1, ADDR_W'($urandom), $urandom);
        repeat (8) begin
            tick();
            vectors++;
            if (pop_cyc.size() !== 0 || busy0 !== 1'b0) begin
                miscompares++; $display("FAIL gate_blocked got pops=%0d busy=%b exp 0/0", pop_cyc.size(), busy0);
            end
        end
        enable = 1'b1;
        c_en = cyc;
        tick();
        vectors++;
        if (pop_cyc.size() !== 1 || (pop_cyc.size() == 1 && pop_cyc[0] !== c_en)) begin
            miscompares++; $display("FAIL gate_release got pops=%0d exp one pop at cycle %0d", pop_cyc.size(), c_en);
        end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a[4];
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            a[i] = ADDR_W'($urandom);
            push_req0(1'b1, a[i], $urandom);
        end
        repeat (16) tick();
        vectors++;
        if (en_cyc.size() !== 4) begin
            miscompares++; $display("FAIL b2b_strobes got=%0d exp=4", en_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (en_cyc[i] - en_cyc[i-1] !== 3) begin
                    miscompares++; $display("FAIL b2b_spacing[%0d] got=%0d exp=3", i, en_cyc[i] - en_cyc[i-1]);
                end
            end
        end
        for (int i = 0; i < 4; i++) push_req0(1'b0, a[3-i], $urandom);
        repeat (24) tick();
        vectors++;
        if (got0.size() !== exp0.size()) begin
            miscompares++; $display("FAIL b2b_rd_count got=%0d exp=%0d", got0.size(), exp0.size());
        end else begin
            for (int i = 0; i < got0.size(); i++) begin
                vectors++;
                if (got0[i] !== exp0[i]) begin
                    miscompares++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, got0[i], exp0[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int guard;
        logic [ADDR_W-1:0] a;
        clear_logs();
        for (int k = 0; k < 40; k++) begin
            a = (k % 5 == 0) ? {ADDR_W{1'b1}} : (k % 7 == 0) ? '0 : ADDR_W'($urandom_range(0, 15));
            push_req0(1'($urandom_range(0, 1)), a, $urandom);
        end
        guard = 0;
        while ((got0.size() < exp0.size() || req_q0.size() != 0 || busy0) && guard < 2000) begin
            enable = $urandom_range(0, 3) != 0;
            resp_full0 = $urandom_range(0, 2) == 0;
            tick();
            guard++;
        end
        enable = 1'b1; resp_full0 = 1'b0;
        tick();
        vectors++;
        if (guard >= 2000 || got0.size() !== exp0.size() || en_cyc.size() !== 40) begin
            miscompares++; $display("FAIL rand_done got rd=%0d strobes=%0d exp rd=%0d strobes=40", got0.size(), en_cyc.size(), exp0.size());
        end else begin
            for (int i = 0; i < got0.size(); i++) begin
                vectors++;
                if (got0[i] !== exp0[i]) begin
                    miscompares++; $display("FAIL rand_rd[%0d] got=%h exp=%h", i, got0[i], exp0[i]);
                end
            end
        end
`ifdef RESP_STATS_EN
        vectors++;
        if (wr_count0 !== 16'(n_wr) || rd_count0 !== 16'(n_rd)) begin
            miscompares++; $display("FAIL rand_stats got wr=%0d rd=%0d exp wr=%0d rd=%0d", wr_count0, rd_count0, n_wr, n_rd);
        end
`endif
    endtask

    task automatic test_latency3();
        int guard;
        exp1.delete(); got1.delete(); en1_q.delete();
        for (int i = 0; i < 6; i++) req_q1.push_back({1'b0, ADDR_W'($urandom), 32'($urandom)});
        req_empty1 = 1'b0;
        guard = 0;
        while (got1.size() < 6 && guard < 200) begin
            tick();
            guard++;
        end
        vectors++;
        if (got1.size() !== 6 || exp1.size() !== 6) begin
            miscompares++; $display("FAIL lat3_count got=%0d expected_words=%0d exp=6", got1.size(), exp1.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got1[i] !== exp1[i]) begin
                    miscompares++; $display("FAIL lat3_rd[%0d] got=%h exp=%h", i, got1[i], exp1[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        clear_logs();
        enable = 1'b1;
        push_req0(1'b0, ADDR_W'($urandom), $urandom);
        repeat (3) tick();
        vectors++;
        if (busy0 !== 1'b1) begin
            miscompares++; $display("FAIL midrd_inflight got busy=%b exp=1", busy0);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({req_pop0, ram_enable0, resp_push0, busy0, ram_read_write0, ram_addr0, ram_data_write0, resp_data0} !== '0) begin
            miscompares++; $display("FAIL midrd_reset got pop=%b en=%b push=%b busy=%b rdata=%h exp all 0", req_pop0, ram_enable0, resp_push0, busy0, resp_data0);
        end
`ifdef RESP_STATS_EN
        vectors++;
        if (rd_count0 !== 16'd0 || wr_count0 !== 16'd0) begin
            miscompares++; $display("FAIL midrd_stats got rd=%0d wr=%0d exp 0/0", rd_count0, wr_count0);
        end
`endif
        reset = 1'b0;
        repeat (6) tick();
        vectors++;
        if (push_cyc.size() !== 0 || busy0 !== 1'b0) begin
            miscompares++; $display("FAIL midrd_abandon got pushes=%0d busy=%b exp 0/0", push_cyc.size(), busy0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NUM_RAM_ADDRESS; i++) begin
            ram_mem[i] = '0; exp_mem[i] = '0;
        end
        test_reset();
        test_single_write();
        test_read_after_write();
        test_backpressure();
        test_gating();
        test_back_to_back();
        test_random();
        test_latency3();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_request_responder.md
Name: ram_request_responder

Overview:
- Sits in the RAM clock domain, between the read side of the processor-to-RAM request FIFO and the write side of the RAM-to-processor response FIFO.
- Pops one packed request {read_write, address, write_data} at a time and unpacks it.
- Drives a single RAM access for that request.
- For reads, pushes the returned 32-bit word into the response FIFO, holding it while that FIFO is full.
- Replaces ad-hoc enable gating with an explicit request/response sequencer.

Parameters:
- NUM_RAM_ADDRESS, 256, RAM depth in words; ADDR_W = $clog2(NUM_RAM_ADDRESS).
- DATA_W, 32, data word width.
- REQ_W, ADDR_W+DATA_W+1, packed request width.
- RAM_READ_LATENCY, 1, cycles from ram_enable (read) to valid ram_data_read; legal range 1..4.

Ports:
- clk  input  1  RAM-domain clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new request is popped; an in-flight request completes.
- req_empty  input  1  request FIFO empty flag.
- req_data  input  REQ_W  request FIFO read data; valid the cycle after req_pop. Bit layout is [REQ_W-1]=read_write, [REQ_W-2:DATA_W]=address, [DATA_W-1:0]=write_data.
- req_pop  output  1  request FIFO read enable; one-cycle pulse.
- ram_enable  output  1  RAM access strobe; one-cycle pulse.
- ram_read_write  output  1  1=write, 0=read.
- ram_addr  output  ADDR_W  RAM address.
- ram_data_write  output  DATA_W  RAM write data.
- ram_data_read  input  DATA_W  RAM read data.
- resp_full  input  1  response FIFO full flag.
- resp_push  output  1  response FIFO write enable; one-cycle pulse.
- resp_data  output  DATA_W  response word; registered and stable while in RESP.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the internal latency counter is 0. Reset asserted mid-transaction abandons the transaction; no pop, RAM strobe or push occurs in the cycle after reset.
- Request capture registers hold rw_q, addr_q and wdata_q; ram_read_write, ram_addr and ram_data_write are driven from these registers.
- States: IDLE, FETCH, EXEC, WAIT_RD, RESP.
- IDLE:
  - If enable && !req_empty, assert req_pop for this cycle and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: capture req_data into rw_q, addr_q and wdata_q; go to EXEC. No outputs asserted.
- EXEC: assert ram_enable for exactly one cycle.
  - If rw_q=1 (write), go to IDLE.
  - If rw_q=0 (read), load the counter with RAM_READ_LATENCY-1 and go to WAIT_RD.
- WAIT_RD:
  - When the counter is 0, capture ram_data_read into resp_data and go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - If !resp_full, assert resp_push for one cycle and go to IDLE.
  - If resp_full, stay in RESP with resp_data held, without bound.
- Timing:
  - Write: 3 cycles per request (pop, capture, strobe); the next pop can occur in the cycle after EXEC.
  - Read with L=1: 5 cycles, pop to push.
- Boundary conditions:
  - enable dropping during FETCH, EXEC, WAIT_RD or RESP does not abort; it only blocks the next IDLE pop.
  - req_empty going high after a pop is ignored for that transaction.
  - resp_full is sampled only in RESP.
  - Addresses are never wrapped or checked; every ADDR_W value is passed through.
  - At most one request is in flight, so response order matches request order.

Optional Feature:
- Macro RESP_STATS_EN, defined: adds output ports rd_count[15:0] and wr_count[15:0].
  - wr_count increments in EXEC when rw_q=1.
  - rd_count increments on each resp_push.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ram_responder_pkg holds:
  - the state enum (IDLE, FETCH, EXEC, WAIT_RD, RESP);
  - localparam bit positions for the request fields;
  - a function unpack_req(req) that returns the rw, addr and wdata fields.
- Sub-module sat_counter16 (increment, clear, saturate) is instantiated twice, only under RESP_STATS_EN.
- The FSM remains flat in ram_request_responder.

Test Plan:
- Single write: push {1, 8'h2A, 32'hDEADBEEF} into an empty FIFO with enable=1. Required response:
  - req_pop high 1 cycle;
  - two cycles after the pop, ram_enable=1 with ram_read_write=1, ram_addr=8'h2A, ram_data_write=32'hDEADBEEF;
  - resp_push never asserted.
- Read after write: request {0, 8'h2A, x} with L=1. Required response:
  - ram_enable with ram_read_write=0;
  - resp_push asserted 4 cycles after req_pop with resp_data=32'hDEADBEEF.
- Back-pressure: hold resp_full=1 for 10 cycles during a read. Required response:
  - the block stays in RESP and busy=1 with resp_data stable;
  - resp_push is asserted in the first cycle with resp_full=0, then the block returns to IDLE.
- Gating: enable=0 with req_empty=0 for 8 cycles -> req_pop stays 0. Then enable=1 -> req_pop asserted the next cycle.
- Streaming and latency:
  - 4 back-to-back writes: ram_enable pulses are exactly 3 cycles apart.
  - RAM_READ_LATENCY=3: resp_data equals the RAM word presented 3 cycles after ram_enable.
- Reset mid-read: assert reset in WAIT_RD. Required response:
  - the next cycle has all outputs 0 and the state IDLE;
  - no resp_push;
  - with RESP_STATS_EN, rd_count=0.
